uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage, the downstream counterpart of the UART transmitter: it consumes the serial line the transmitter drives. It recovers frames of the form start(0), data[0]..data[7] LSB first, parity, stop(1). Each byte is presented on a parallel port with a sticky ready flag that the consumer clears. Parity, framing and overrun errors are reported alongside the data.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per bit period; must be ≥ 4.
- PARITY_ODD, default 0: 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- serial_input_rx  in  1  asynchronous serial line; idles high.
- clear_rx_flag  in  1  consumer acknowledge, level-sampled; clears rx_flag.
- rx_data  out  8  last received byte (uint8_t).
- rx_flag  out  1  sticky byte-ready flag.
- parity_error  out  1  parity mismatch on the byte in rx_data.
- framing_error  out  1  stop bit sampled 0 on the byte in rx_data.
- overrun  out  1  a byte was written while rx_flag was still set; cleared with rx_flag.
- busy  out  1  high from confirmed start bit until the stop-bit sample.

## Operation
- Input passes a 2-flop synchronizer (both flops reset to 1). All logic below uses the synchronized value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: rx_s = 0 → START, baud counter loaded with ⌊CLKS_PER_BIT/2⌋−1.
- START: at counter expiry, sample rx_s.
  - 1 = glitch → IDLE, no outputs change.
  - 0 → DATA, bit index 0, counter reloaded with CLKS_PER_BIT−1.
- DATA: at each expiry, shift rx_s into the shift register at position index (LSB first). After index 7 → PARITY.
- PARITY: at expiry, latch the parity bit → STOP.
- STOP: at expiry, sample the stop bit and perform the write: rx_data ← shift register; parity_error ← computed parity ≠ received parity; framing_error ← stop bit == 0; overrun ← rx_flag (pre-write value); rx_flag ← 1. Then → IDLE.
- A frame with framing_error is still delivered.
- After a framing error, IDLE re-arms only once rx_s has been 1 for one cycle (break condition does not retrigger).
- rx_flag: cleared when clear_rx_flag = 1 and no write occurs that cycle. Write and clear in the same cycle: the write wins and rx_flag stays 1. Clearing also clears overrun; parity_error and framing_error hold until the next write.
- clear_rx_flag while rx_flag = 0 has no effect.
- Reset, including mid-frame: FSM → IDLE, counters 0, rx_data = 8'h00, all flags 0, busy 0, synchronizer = 1. A partial frame is discarded.

## Timing
- Cycle 0 = first cycle rx_s is low (2 clk after the line falls).
- Start sample at cycle ⌊N/2⌋; bit k sample (k = 0..7) at ⌊N/2⌋ + (k+1)N; parity at ⌊N/2⌋ + 9N; stop at ⌊N/2⌋ + 10N.
- rx_data and flags are valid, and rx_flag is high, from cycle ⌊N/2⌋ + 10N + 1 (registered write).
- busy rises at cycle ⌊N/2⌋ + 1 and falls together with the write.
- Back-to-back frames: the next start edge may be detected in the cycle after the stop sample.
- No back-pressure. Data is lost only via overwrite, which is flagged by overrun.

## Structure
- The DataTypes package supplies bit_t and uint8_t. Add rx_state_t (the 5-state enum) and the baud-counter width function $clog2(CLKS_PER_BIT) to the package.
- One sub-module: uart_rx_baud_counter (load value, load strobe, expiry pulse). The FSM, shift register, parity check and flag logic stay in uart_receiver.

## Test plan
- N=16, send 8'hA5 with even parity 0 and stop 1 → rx_data=8'hA5, rx_flag=1 at cycle 169, parity_error=0, framing_error=0.
- Send 8'h01 with parity bit 0 (wrong for even) → rx_data=8'h01, parity_error=1. Then send 8'h03 with a correct parity bit → parity_error=0.
- 3-cycle low glitch on an idle line → FSM returns to IDLE; rx_flag, busy and rx_data unchanged.
- Two frames 8'h11 then 8'h22, clear_rx_flag never asserted → rx_data=8'h22, overrun=1. Pulse clear_rx_flag → rx_flag=0, overrun=0.
- Stop bit driven 0 on 8'h3C → rx_data=8'h3C, framing_error=1. Hold the line low → no new frame until it returns high.
- Assert reset (0) during DATA bit 4 → all outputs 0 next cycle. The following clean 8'h5A frame is received correctly. Also check clear_rx_flag coinciding with the write cycle → rx_flag stays 1.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared types for the UART receive path.
// Holds the data aliases, FSM state enum and baud-counter sizing.
package uart_receiver_pkg;

    typedef logic       bit_t;
    typedef logic [7:0] uint8_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Bits needed to hold a count of 0..clks_per_bit-1.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_rx_baud_counter.sv
// Down-counter pacing the receiver's bit sampling.
// Expiry is high whenever the count sits at zero.
module uart_rx_baud_counter
    import uart_receiver_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 16,
    localparam int W            = baud_cnt_width(CLKS_PER_BIT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output bit_t         o_expire
);

    logic [W-1:0] r_cnt;

    // Load on strobe, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start, 8 data LSB first, parity, stop.
// Delivers each byte with a sticky flag plus error status.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   serial_input_rx,
    input  logic   clear_rx_flag,
    output uint8_t rx_data,
    output bit_t   rx_flag,
    output bit_t   parity_error,
    output bit_t   framing_error,
    output bit_t   overrun,
    output bit_t   busy
);

    localparam int W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);

    rx_state_t    r_state;
    rx_state_t    w_state_nxt;
    logic         r_sync1;
    logic         r_rx_s;
    logic         r_armed;
    logic [2:0]   r_idx;
    uint8_t       r_shift;
    logic         r_par_bit;
    uint8_t       r_data;
    logic         r_flag;
    logic         r_pe;
    logic         r_fe;
    logic         r_ovr;
    logic         w_expire;
    logic         w_load;
    logic [W-1:0] w_load_val;
    logic         w_sample;
    logic         w_latch_par;
    logic         w_write;
    logic         w_par_calc;

    uart_rx_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= serial_input_rx;
            r_rx_s  <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_sample    = 1'b0;
        w_latch_par = 1'b0;
        w_write     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_armed && !r_rx_s) begin
                    w_state_nxt = START;
                    w_load      = 1'b1;
                    w_load_val  = HALF;
                end
            end
            START: begin
                if (w_expire) begin
                    if (r_rx_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                        w_load      = 1'b1;
                        w_load_val  = FULL;
                    end
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_sample   = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = FULL;
                    if (r_idx == 3'd7) w_state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (w_expire) begin
                    w_latch_par = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = FULL;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_expire) begin
                    w_write     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_par_calc = (PARITY_ODD != 0) ? ~^r_shift : ^r_shift;

    // Shift register, delivery registers, sticky flags and break re-arm.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
            r_par_bit <= 1'b0;
            r_data    <= 8'h00;
            r_flag    <= 1'b0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_ovr     <= 1'b0;
            r_armed   <= 1'b1;
        end else begin
            if (r_state == IDLE) r_idx <= 3'd0;
            else if (w_sample)   r_idx <= r_idx + 3'd1;
            if (w_sample)    r_shift[r_idx] <= r_rx_s;
            if (w_latch_par) r_par_bit      <= r_rx_s;
            if (w_write) begin
                r_data  <= r_shift;
                r_pe    <= (w_par_calc != r_par_bit);
                r_fe    <= !r_rx_s;
                r_ovr   <= r_flag;
                r_flag  <= 1'b1;
                r_armed <= r_rx_s;
            end else begin
                if (clear_rx_flag) begin
                    r_flag <= 1'b0;
                    r_ovr  <= 1'b0;
                end
                if (r_state == IDLE && !r_armed && r_rx_s) r_armed <= 1'b1;
            end
        end
    end

    assign rx_data       = r_data;
    assign rx_flag       = r_flag;
    assign parity_error  = r_pe;
    assign framing_error = r_fe;
    assign overrun       = r_ovr;
    assign busy          = (r_state inside {DATA, PARITY, STOP});

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit, even parity.
// Each scenario task drives frames and checks outputs inline.
module tb_uart_receiver;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_input_rx = 1'b1;
    logic       clear_rx_flag = 1'b0;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       parity_error;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    uart_receiver #(
        .CLKS_PER_BIT (N),
        .PARITY_ODD   (0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .serial_input_rx (serial_input_rx),
        .clear_rx_flag   (clear_rx_flag),
        .rx_data         (rx_data),
        .rx_flag         (rx_flag),
        .parity_error    (parity_error),
        .framing_error   (framing_error),
        .overrun         (overrun),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_rx_flag = 1'b1;
        tick(1);
        clear_rx_flag = 1'b0;
    endtask

    // Drives one frame; reports the edge (counted from the line falling)
    // at which rx_flag first rose, and can raise clear_rx_flag for the
    // single edge number clr_edge.
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int clr_edge,
                              output int rise);
        logic [10:0] f;
        logic        prev;
        int          e;
        f    = {s, p, d, 1'b0};
        rise = -1;
        prev = rx_flag;
        e    = 0;
        for (int i = 0; i < 11; i++) begin
            serial_input_rx = f[i];
            for (int c = 0; c < N; c++) begin
                @(posedge clk);
                #1;
                e++;
                clear_rx_flag = (e == clr_edge - 1);
                if (rise < 0 && !prev && rx_flag) rise = e;
                prev = rx_flag;
            end
        end
        clear_rx_flag = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        n_vec++;
        if ({rx_data, rx_flag, parity_error, framing_error, overrun, busy}
                !== 13'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b want 00/00000",
                     rx_data, rx_flag, parity_error, framing_error,
                     overrun, busy);
        end
        reset = 1'b1;
        tick(5);
    endtask

    task automatic test_basic();
        int rise;
        send_frame(8'hA5, 1'b0, 1'b1, 0, rise);
        n_vec++;
        if (rise !== 171) begin
            n_err++;
            $display("FAIL basic_flag_edge: got %0d want 171", rise);
        end
        n_vec++;
        if (rx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL basic_data: got %h want a5", rx_data);
        end
        n_vec++;
        if ({parity_error, framing_error, overrun, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL basic_status: got %b%b%b%b want 0000",
                     parity_error, framing_error, overrun, busy);
        end
        pulse_clear();
        n_vec++;
        if (rx_flag !== 1'b0) begin
            n_err++;
            $display("FAIL basic_clear: got %b want 0", rx_flag);
        end
        tick(4);
    endtask

    task automatic test_parity();
        int rise;
        send_frame(8'h01, 1'b0, 1'b1, 0, rise);
        n_vec++;
        if ({rx_data, parity_error} !== {8'h01, 1'b1}) begin
            n_err++;
            $display("FAIL parity_bad: got %h/%b want 01/1",
                     rx_data, parity_error);
        end
        pulse_clear();
        tick(4);
        send_frame(8'h03, 1'b0, 1'b1, 0, rise);
        n_vec++;
        if ({rx_data, parity_error, rx_flag} !== {8'h03, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL parity_good: got %h/%b/%b want 03/0/1",
                     rx_data, parity_error, rx_flag);
        end
        pulse_clear();
        tick(4);
    endtask

    task automatic test_glitch();
        logic saw_busy;
        saw_busy = 1'b0;
        serial_input_rx = 1'b0;
        tick(3);
        serial_input_rx = 1'b1;
        for (int c = 0; c < 3 * N; c++) begin
            tick(1);
            if (busy) saw_busy = 1'b1;
        end
        n_vec++;
        if ({saw_busy, rx_flag, rx_data} !== {1'b0, 1'b0, 8'h03}) begin
            n_err++;
            $display("FAIL glitch_ignored: got busy=%b flag=%b data=%h want 0/0/03",
                     saw_busy, rx_flag, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int rise;
        send_frame(8'h11, 1'b0, 1'b1, 0, rise);
        n_vec++;
        if ({rx_data, rx_flag, overrun} !== {8'h11, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_first: got %h/%b/%b want 11/1/0",
                     rx_data, rx_flag, overrun);
        end
        send_frame(8'h22, 1'b0, 1'b1, 0, rise);
        n_vec++;
        if ({rx_data, rx_flag, overrun} !== {8'h22, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_overrun: got %h/%b/%b want 22/1/1",
                     rx_data, rx_flag, overrun);
        end
        pulse_clear();
        n_vec++;
        if ({rx_flag, overrun} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_clear: got %b/%b want 0/0", rx_flag, overrun);
        end
        tick(4);
    endtask

    task automatic test_framing();
        int   rise;
        logic saw;
        send_frame(8'h3C, 1'b0, 1'b0, 0, rise);
        n_vec++;
        if ({rx_data, framing_error, parity_error, rx_flag}
                !== {8'h3C, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL framing_deliver: got %h/%b/%b/%b want 3c/1/0/1",
                     rx_data, framing_error, parity_error, rx_flag);
        end
        pulse_clear();
        saw = 1'b0;
        for (int c = 0; c < 12 * N; c++) begin
            tick(1);
            if (busy || rx_flag) saw = 1'b1;
        end
        n_vec++;
        if ({saw, framing_error} !== 2'b01) begin
            n_err++;
            $display("FAIL framing_break_hold: got activity=%b fe=%b want 0/1",
                     saw, framing_error);
        end
        serial_input_rx = 1'b1;
        tick(20);
        send_frame(8'h81, 1'b0, 1'b1, 0, rise);
        n_vec++;
        if ({rx_data, framing_error, rx_flag} !== {8'h81, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL framing_rearm: got %h/%b/%b want 81/0/1",
                     rx_data, framing_error, rx_flag);
        end
        tick(4);
    endtask

    task automatic test_reset_midframe();
        int rise;
        serial_input_rx = 1'b0;
        tick(N);
        for (int i = 0; i < 4; i++) begin
            serial_input_rx = i[0] ? 1'b1 : 1'b0;
            tick(N);
        end
        serial_input_rx = 1'b1;
        tick(N / 2);
        reset = 1'b0;
        tick(1);
        n_vec++;
        if ({rx_data, rx_flag, parity_error, framing_error, overrun, busy}
                !== 13'h0) begin
            n_err++;
            $display("FAIL midframe_reset: got %h/%b%b%b%b%b want 00/00000",
                     rx_data, rx_flag, parity_error, framing_error,
                     overrun, busy);
        end
        reset = 1'b1;
        tick(2 * N);
        send_frame(8'h5A, 1'b0, 1'b1, 0, rise);
        n_vec++;
        if ({rx_data, parity_error, framing_error, overrun}
                !== {8'h5A, 3'b000} || rise !== 171) begin
            n_err++;
            $display("FAIL after_reset_frame: got %h/%b%b%b edge %0d want 5a/000 edge 171",
                     rx_data, parity_error, framing_error, overrun, rise);
        end
        pulse_clear();
        tick(4);
    endtask

    task automatic test_clear_on_write();
        int rise;
        send_frame(8'hC3, 1'b0, 1'b1, 171, rise);
        n_vec++;
        if ({rx_data, rx_flag, overrun} !== {8'hC3, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL clear_on_write: got %h/%b/%b want c3/1/0",
                     rx_data, rx_flag, overrun);
        end
        tick(4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_back_to_back();
        test_framing();
        test_reset_midframe();
        test_clear_on_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
